// File: rtl/isi_channel_model.sv
// Symbol-rate ISI channel model: symmetric pre/post-cursor taps, loadable coefficients, saturating 4-stage pipeline.
// Optional pseudo-noise injection into the ISI term is enabled by defining ISI_NOISE_EN.
module isi_channel_model #(
  parameter int                            DATA_WIDTH    = 18,
  parameter int                            COEF_WIDTH    = 18,
  parameter int                            NUM_SIDE_TAPS = 2,
  parameter int                            CHANNEL_GAIN  = 1,
  parameter logic signed [COEF_WIDTH-1:0]  DEFAULT_COEF  = 18'sd9268,
  parameter int                            NOISE_BITS    = 4,
  localparam int                           AW = (NUM_SIDE_TAPS > 1) ? $clog2(NUM_SIDE_TAPS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         coef_wr,
  input  logic [AW-1:0]                coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                         coef_commit,
  output logic                         coef_busy,
  input  logic                         sat_clear,
  output logic                         sat_flag,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] decision_variable,
  output logic signed [DATA_WIDTH-1:0] errorless_decision_variable,
  output logic signed [DATA_WIDTH-1:0] error
);

  localparam int DW     = DATA_WIDTH;
  localparam int CW     = COEF_WIDTH;
  localparam int N      = NUM_SIDE_TAPS;
  localparam int L      = 2 * N + 1;
  localparam int PS_W   = DW + 1;
  localparam int WIDE_W = DW + CW + 1;
  localparam int ACC_W  = DW + $clog2(N) + 1;
  localparam int FILL   = 2 * N + 4;
  localparam int CNT_W  = $clog2(FILL + 1);

  localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic is_clip(input logic signed [WIDE_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [WIDE_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction

  logic signed [DW-1:0]    d      [L];
  logic signed [PS_W-1:0]  ps     [N];
  logic signed [DW-1:0]    p      [N];
  logic signed [DW-1:0]    main1, main2;
  logic signed [CW-1:0]    shadow [N];
  logic signed [CW-1:0]    active [N];
  logic                    pending;
  logic [CNT_W-1:0]        fill_cnt;
  logic signed [ACC_W-1:0] noise;

  assign coef_busy = pending;

  // S2 products: full-precision multiply, rescale by the coefficient's fractional bits, then clip.
  logic signed [DW-1:0]     p_next [N];
  logic signed [WIDE_W-1:0] prod, prod_sh;
  logic                     s2_clip;

  // NOTE: every always_comb output gets a default before any loop or branch so no latch can be inferred.
  always_comb begin
    p_next  = '{default: '0};
    prod    = '0;
    prod_sh = '0;
    s2_clip = 1'b0;
    for (int i = 0; i < N; i++) begin
      prod      = WIDE_W'(ps[i]) * WIDE_W'(active[i]);
      prod_sh   = prod >>> (CW - 1);
      p_next[i] = sat_dw(prod_sh);
      s2_clip   = s2_clip | is_clip(prod_sh);
    end
  end

  logic signed [ACC_W-1:0]  acc, acc_sh;
  logic signed [WIDE_W-1:0] dec_sum;
  logic signed [DW-1:0]     error_next, errorless_next, decision_next;
  logic                     s3_clip;

  always_comb begin
    acc = noise;
    for (int i = 0; i < N; i++) acc = acc + ACC_W'(p[i]);
    acc_sh         = acc >>> CHANNEL_GAIN;
    error_next     = sat_dw(WIDE_W'(acc_sh));
    errorless_next = main2 >>> CHANNEL_GAIN;
    dec_sum        = WIDE_W'(errorless_next) + WIDE_W'(error_next);
    decision_next  = sat_dw(dec_sum);
    s3_clip        = is_clip(WIDE_W'(acc_sh)) | is_clip(dec_sum);
  end

`ifdef ISI_NOISE_EN
  logic [22:0] lfsr;

  // x^23 + x^18 + 1 Fibonacci form, advancing once per symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lfsr <= 23'h1;
    else if (clk_en) lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
  end

  assign noise = ACC_W'($signed(lfsr[NOISE_BITS-1:0]));
`else
  assign noise = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every stage reads the pre-edge value of the one before.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) d[i] <= '0;
      for (int i = 0; i < N; i++) begin
        ps[i] <= '0;
        p[i]  <= '0;
      end
      main1                       <= '0;
      main2                       <= '0;
      error                       <= '0;
      errorless_decision_variable <= '0;
      decision_variable           <= '0;
    end else if (clk_en) begin
      d[0] <= in_data;
      for (int i = 1; i < L; i++) d[i] <= d[i-1];
      for (int i = 0; i < N; i++) ps[i] <= PS_W'(d[N-1-i]) + PS_W'(d[N+1+i]);
      main1                       <= d[N];
      p                           <= p_next;
      main2                       <= main1;
      error                       <= error_next;
      errorless_decision_variable <= errorless_next;
      decision_variable           <= decision_next;
    end
  end

  // NOTE: the coefficient banks are tiny register files and must come up with a known channel, so they take the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= (i == 0) ? DEFAULT_COEF : '0;
        active[i] <= (i == 0) ? DEFAULT_COEF : '0;
      end
      pending <= 1'b0;
    end else begin
      if (coef_wr && (int'(coef_addr) < N)) shadow[coef_addr] <= coef_data;
      // Copy only on a symbol edge; active sees shadow as it stood before any same-cycle write.
      if (clk_en) begin
        if (pending || coef_commit) active <= shadow;
        pending <= 1'b0;
      end else if (coef_commit) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag  <= 1'b0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clk_en && (s2_clip || s3_clip)) sat_flag <= 1'b1;
      else if (sat_clear)                 sat_flag <= 1'b0;
      if (clk_en && (fill_cnt != CNT_W'(FILL))) fill_cnt <= fill_cnt + CNT_W'(1);
      if (clk_en && (fill_cnt == CNT_W'(FILL - 1))) out_valid <= 1'b1;
    end
  end

endmodule
